// File: rtl/pwl_act_pipe.sv
// Pipelined piecewise-linear activation: rescales a wide signed word with round-half-up, then
// applies a per-sample activation (saturate, ReLU, symmetric clamp, bounded ReLU).
module pwl_act_pipe #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned IN_WIDTH = 2 * WIDTH,
    parameter int unsigned SHIFT    = WIDTH - 1,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [IN_WIDTH-1:0] in_data,
    input  logic [1:0]          in_mode,
    input  logic [WIDTH-1:0]    in_thr,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIDTH-1:0]    out_data,
    output logic                out_sat,
    input  logic                sat_clr,
    output logic [CNT_W-1:0]    sat_count
);

    // One guard bit so the rounding add of the most positive input cannot overflow.
    localparam int unsigned RW = IN_WIDTH + 1;
    localparam logic [RW-1:0] RND = ({{(RW - 1){1'b0}}, 1'b1} << SHIFT) >> 1;
    localparam logic signed [RW-1:0] MAX_V = RW'({1'b0, {(WIDTH - 1){1'b1}}});
    localparam logic signed [RW-1:0] MIN_V = ~MAX_V;

    logic en;

    logic                s1_valid;
    logic [IN_WIDTH-1:0] s1_data;
    logic [1:0]          s1_mode;
    logic [WIDTH-1:0]    s1_thr;

    logic                 s2_valid;
    logic signed [RW-1:0] s2_r;
    logic [1:0]           s2_mode;
    logic [WIDTH-1:0]     s2_thr;

    logic signed [RW-1:0] x_ext;
    logic signed [RW-1:0] r_sum;
    logic signed [RW-1:0] r_next;

    logic signed [RW-1:0] thr_ext;
    logic signed [RW-1:0] hi;
    logic signed [RW-1:0] lo;
    logic                 zero_neg;
    logic [WIDTH-1:0]     act_res;
    logic                 act_sat;

    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    always_comb begin
        x_ext  = {s1_data[IN_WIDTH-1], s1_data};
        r_sum  = x_ext + $signed(RND);
        r_next = r_sum >>> SHIFT;
    end

    always_comb begin
        thr_ext = '0;
        if (!s2_thr[WIDTH-1]) begin
            thr_ext = {{(RW - WIDTH){1'b0}}, s2_thr};
        end
        hi       = MAX_V;
        lo       = MIN_V;
        zero_neg = 1'b0;
        unique case (s2_mode)
            2'd0: ;
            2'd1: zero_neg = 1'b1;
            2'd2: begin
                hi = thr_ext;
                lo = -thr_ext;
            end
            2'd3: begin
                hi       = thr_ext;
                zero_neg = 1'b1;
            end
        endcase

        // Zeroing negatives in the ReLU modes is a transfer-function choice, not saturation.
        act_res = s2_r[WIDTH-1:0];
        act_sat = 1'b0;
        if (zero_neg && s2_r[RW-1]) begin
            act_res = '0;
        end else if (s2_r > hi) begin
            act_res = hi[WIDTH-1:0];
            act_sat = 1'b1;
        end else if (s2_r < lo) begin
            act_res = lo[WIDTH-1:0];
            act_sat = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_data   <= '0;
            s1_mode   <= '0;
            s1_thr    <= '0;
            s2_valid  <= 1'b0;
            s2_r      <= '0;
            s2_mode   <= '0;
            s2_thr    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
        end else if (en) begin
            s1_valid  <= in_valid;
            s1_data   <= in_data;
            s1_mode   <= in_mode;
            s1_thr    <= in_thr;
            s2_valid  <= s1_valid;
            s2_r      <= r_next;
            s2_mode   <= s1_mode;
            s2_thr    <= s1_thr;
            out_valid <= s2_valid;
            out_data  <= act_res;
            out_sat   <= act_sat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sat_count <= '0;
        end else if (sat_clr) begin
            sat_count <= '0;
        end else if (out_valid && out_ready && out_sat && (sat_count != {CNT_W{1'b1}})) begin
            sat_count <= sat_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_pwl_act_pipe.sv
// Bench for pwl_act_pipe (WIDTH=8, IN_WIDTH=16, SHIFT=4, CNT_W=2): directed cases plus
// randomized traffic checked against an interval-clamp reference model.
module tb_pwl_act_pipe;

    localparam int W  = 8;
    localparam int IW = 16;
    localparam int SH = 4;
    localparam int CW = 2;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [IW-1:0] in_data;
    logic [1:0]    in_mode;
    logic [W-1:0]  in_thr;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic          out_sat;
    logic          sat_clr;
    logic [CW-1:0] sat_count;

    int checks   = 0;
    int failures = 0;
    int model_cnt = 0;

    logic [8:0] exp_q[$];
    logic [8:0] hs_exp[$];
    logic [8:0] hs_got[$];

    always #5 clk = ~clk;

    pwl_act_pipe #(
        .WIDTH   (W),
        .IN_WIDTH(IW),
        .SHIFT   (SH),
        .CNT_W   (CW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_mode  (in_mode),
        .in_thr   (in_thr),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_sat  (out_sat),
        .sat_clr  (sat_clr),
        .sat_count(sat_count)
    );

    // Reference: round-half-up division by 2^SH, then limit to a mode-dependent interval.
    function automatic logic [8:0] model(logic [15:0] data, logic [1:0] mode, logic [7:0] thr);
        int x, r, t, lo, hi, v;
        logic s;
        x = int'($signed(data));
        r = (x + (1 << (SH - 1))) >>> SH;
        t = thr[7] ? 0 : int'(thr);
        case (mode)
            2'd0:    begin lo = -128; hi = 127; end
            2'd1:    begin lo = 0;    hi = 127; end
            2'd2:    begin lo = -t;   hi = t;   end
            default: begin lo = 0;    hi = t;   end
        endcase
        s = 1'b0;
        v = r;
        if ((mode == 2'd1 || mode == 2'd3) && r < 0) begin
            v = 0;
        end else if (r > hi) begin
            v = hi;
            s = 1'b1;
        end else if (r < lo) begin
            v = lo;
            s = 1'b1;
        end
        return {s, v[7:0]};
    endfunction

    // One clock: records accepts/handshakes into the scoreboard, returns at the next negedge.
    task automatic tick(output bit acc);
        bit hs;
        logic [8:0] e;
        #1;
        acc = in_valid && in_ready && !rst;
        hs  = out_valid && out_ready;
        if (rst) begin
            exp_q.delete();
            model_cnt = 0;
        end else begin
            if (hs) begin
                hs_got.push_back({out_sat, out_data});
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 9'bx;
                hs_exp.push_back(e);
            end
            if (sat_clr) model_cnt = 0;
            else if (hs && e[8] === 1'b1 && model_cnt < CNT_MAX) model_cnt++;
            if (acc) exp_q.push_back(model(in_data, in_mode, in_thr));
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [15:0] d, input logic [1:0] m,
                         input logic [7:0] t);
        in_valid = v;
        in_data  = d;
        in_mode  = m;
        in_thr   = t;
    endtask

    task automatic clear_hs();
        hs_got.delete();
        hs_exp.delete();
    endtask

    task automatic test_reset();
        bit a;
        rst = 1'b1;
        drive(1'b0, 16'h0, 2'd0, 8'h0);
        out_ready = 1'b1;
        sat_clr = 1'b0;
        tick(a);
        tick(a);
        rst = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== 8'h00) begin failures++; $display("FAIL reset_out_data got=%h exp=00", out_data); end
        checks++; if (out_sat !== 1'b0) begin failures++; $display("FAIL reset_out_sat got=%b exp=0", out_sat); end
        checks++; if (sat_count !== 2'd0) begin failures++; $display("FAIL reset_sat_count got=%0d exp=0", sat_count); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        clear_hs();
    endtask

    task automatic test_rounding();
        bit a;
        logic [8:0] want[3];
        want = '{9'h002, 9'h0FF, 9'h000};
        clear_hs();
        out_ready = 1'b1;
        drive(1'b1, 16'd24, 2'd0, 8'h0);
        tick(a);
        drive(1'b0, 16'h0, 2'd0, 8'h0);
        tick(a);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL latency_early got=%b exp=0", out_valid); end
        tick(a);
        checks++; if (out_valid !== 1'b1 || out_data !== 8'h02) begin failures++; $display("FAIL latency_3 got=%b/%h exp=1/02", out_valid, out_data); end
        drive(1'b1, 16'hFFE8, 2'd0, 8'h0);
        tick(a);
        drive(1'b1, 16'h0000, 2'd0, 8'h0);
        tick(a);
        drive(1'b0, 16'h0, 2'd0, 8'h0);
        for (int i = 0; i < 5; i++) tick(a);
        checks++; if (hs_got.size() !== 3) begin failures++; $display("FAIL round_count got=%0d exp=3", hs_got.size()); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (hs_got[i] !== want[i]) begin failures++; $display("FAIL round_%0d got=%h exp=%h", i, hs_got[i], want[i]); end
        end
        checks++; if (sat_count !== 2'd0) begin failures++; $display("FAIL round_sat_count got=%0d exp=0", sat_count); end
    endtask

    task automatic test_saturation();
        bit a;
        logic [8:0] want[2];
        want = '{9'h17F, 9'h180};
        clear_hs();
        drive(1'b1, 16'h7FFF, 2'd0, 8'h0);
        tick(a);
        drive(1'b1, 16'h8000, 2'd0, 8'h0);
        tick(a);
        drive(1'b0, 16'h0, 2'd0, 8'h0);
        for (int i = 0; i < 5; i++) tick(a);
        checks++; if (hs_got.size() !== 2) begin failures++; $display("FAIL sat_len got=%0d exp=2", hs_got.size()); end
        for (int i = 0; i < 2; i++) begin
            checks++; if (hs_got[i] !== want[i]) begin failures++; $display("FAIL sat_%0d got=%h exp=%h", i, hs_got[i], want[i]); end
        end
        checks++; if (sat_count !== 2'd2) begin failures++; $display("FAIL sat_count2 got=%0d exp=2", sat_count); end
    endtask

    task automatic test_modes();
        bit a;
        logic [15:0] d[5];
        logic [1:0]  m[5];
        logic [7:0]  t[5];
        logic [8:0]  want[5];
        d    = '{16'hFF9C, 16'd1000, 16'hFC18, 16'd200, 16'd1000};
        m    = '{2'd1, 2'd2, 2'd2, 2'd3, 2'd2};
        t    = '{8'd32, 8'd32, 8'd32, 8'd32, 8'h90};
        want = '{9'h000, 9'h120, 9'h1E0, 9'h00D, 9'h100};
        clear_hs();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, d[i], m[i], t[i]);
            tick(a);
        end
        drive(1'b0, 16'h0, 2'd0, 8'h0);
        for (int i = 0; i < 5; i++) tick(a);
        for (int i = 0; i < 5; i++) begin
            checks++; if (hs_got[i] !== want[i]) begin failures++; $display("FAIL mode_%0d got=%h exp=%h", i, hs_got[i], want[i]); end
        end
        // Five saturating outputs so far; a 2-bit counter must stick at 3.
        checks++; if (sat_count !== 2'd3) begin failures++; $display("FAIL sat_count_stick got=%0d exp=3", sat_count); end
    endtask

    task automatic test_sat_clr();
        bit a;
        int n;
        clear_hs();
        out_ready = 1'b0;
        drive(1'b1, 16'h7FFF, 2'd0, 8'h0);
        tick(a);
        drive(1'b0, 16'h0, 2'd0, 8'h0);
        n = 0;
        while (out_valid !== 1'b1 && n < 10) begin
            tick(a);
            n++;
        end
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL clr_wait got=%b exp=1", out_valid); end
        out_ready = 1'b1;
        sat_clr = 1'b1;
        tick(a);
        sat_clr = 1'b0;
        checks++; if (sat_count !== 2'd0) begin failures++; $display("FAIL clr_wins got=%0d exp=0", sat_count); end
        checks++; if (hs_got.size() !== 1 || hs_got[0] !== 9'h17F) begin failures++; $display("FAIL clr_out got=%h exp=17f", hs_got[0]); end
    endtask

    task automatic test_back_to_back();
        bit a, seen;
        int i, stall;
        logic [7:0] held;
        logic [15:0] d[6];
        logic [1:0]  m[6];
        logic [7:0]  t[6];
        for (int k = 0; k < 6; k++) begin
            d[k] = 16'($urandom());
            m[k] = 2'($urandom_range(0, 3));
            t[k] = 8'($urandom_range(0, 255));
        end
        clear_hs();
        i = 0;
        stall = 0;
        seen = 1'b0;
        held = 8'h0;
        for (int c = 0; c < 30; c++) begin
            seen = seen || (out_valid === 1'b1);
            out_ready = !(seen && stall < 4);
            if (!out_ready) stall++;
            if (i < 6) drive(1'b1, d[i], m[i], t[i]);
            else drive(1'b0, 16'h0, 2'd0, 8'h0);
            #1;
            if (!out_ready && out_valid) begin
                checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready got=%b exp=0", in_ready); end
                if (stall >= 2) begin
                    checks++; if (out_data !== held) begin failures++; $display("FAIL bp_stable got=%h exp=%h", out_data, held); end
                end
            end
            held = out_data;
            tick(a);
            if (a) i++;
        end
        checks++; if (hs_got.size() !== 6 || exp_q.size() !== 0) begin failures++; $display("FAIL bp_count got=%0d exp=6", hs_got.size()); end
        for (int k = 0; k < hs_got.size(); k++) begin
            checks++; if (hs_got[k] !== hs_exp[k]) begin failures++; $display("FAIL bp_%0d got=%h exp=%h", k, hs_got[k], hs_exp[k]); end
        end
    endtask

    task automatic test_random();
        bit a;
        int sent, errs, n;
        clear_hs();
        sent = 0;
        for (int c = 0; c < 3000 && sent < 200; c++) begin
            if ($urandom_range(0, 1) == 0)
                drive($urandom_range(0, 3) != 0, 16'($urandom_range(0, 4095) - 2048),
                      2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
            else
                drive($urandom_range(0, 3) != 0, 16'($urandom()),
                      2'($urandom_range(0, 3)), 8'($urandom_range(0, 127)));
            out_ready = ($urandom_range(0, 3) != 0);
            sat_clr   = ($urandom_range(0, 15) == 0);
            tick(a);
            if (a) sent++;
        end
        drive(1'b0, 16'h0, 2'd0, 8'h0);
        out_ready = 1'b1;
        sat_clr = 1'b0;
        n = 0;
        while ((exp_q.size() > 0 || out_valid === 1'b1) && n < 20) begin
            tick(a);
            n++;
        end
        checks++; if (hs_got.size() !== 200 || exp_q.size() !== 0) begin failures++; $display("FAIL rand_count got=%0d exp=200", hs_got.size()); end
        errs = 0;
        for (int k = 0; k < hs_got.size(); k++) begin
            checks++;
            if (hs_got[k] !== hs_exp[k]) begin
                failures++;
                if (errs < 10) $display("FAIL rand_%0d got=%h exp=%h", k, hs_got[k], hs_exp[k]);
                errs++;
            end
        end
        checks++; if (sat_count !== CW'(model_cnt)) begin failures++; $display("FAIL rand_sat_count got=%0d exp=%0d", sat_count, model_cnt); end
    endtask

    task automatic test_reset_midstream();
        bit a;
        clear_hs();
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 16'h7FFF, 2'd0, 8'h0);
            tick(a);
        end
        drive(1'b0, 16'h0, 2'd0, 8'h0);
        rst = 1'b1;
        tick(a);
        rst = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== 8'h00) begin failures++; $display("FAIL mid_out_data got=%h exp=00", out_data); end
        checks++; if (sat_count !== 2'd0) begin failures++; $display("FAIL mid_sat_count got=%0d exp=0", sat_count); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL mid_in_ready got=%b exp=1", in_ready); end
        clear_hs();
        for (int k = 0; k < 5; k++) tick(a);
        checks++; if (hs_got.size() !== 0) begin failures++; $display("FAIL mid_ghost got=%0d exp=0", hs_got.size()); end
        drive(1'b1, 16'd24, 2'd0, 8'h0);
        tick(a);
        drive(1'b0, 16'h0, 2'd0, 8'h0);
        tick(a);
        tick(a);
        checks++; if (out_valid !== 1'b1 || out_data !== 8'h02) begin failures++; $display("FAIL mid_next got=%b/%h exp=1/02", out_valid, out_data); end
        for (int k = 0; k < 3; k++) tick(a);
        checks++; if (hs_got.size() !== 1) begin failures++; $display("FAIL mid_next_count got=%0d exp=1", hs_got.size()); end
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 16'h0, 2'd0, 8'h0);
        out_ready = 1'b1;
        sat_clr = 1'b0;
        @(negedge clk);
        test_reset();
        test_rounding();
        test_saturation();
        test_modes();
        test_sat_clr();
        test_back_to_back();
        test_random();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
